// File: rtl/intersection_controller_pkg.sv
// Shared state encoding and lamp decode for the intersection controller.
// Build option: INTERSECTION_NIGHT_FLASH_EN enables the night-flash mode.
package intersection_controller_pkg;

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_ALL_RED_1   = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_ALL_RED_2   = 3'd5,
    ST_FLASH       = 3'd6
  } state_t;

  typedef struct packed {
    logic main_red;
    logic main_yellow;
    logic main_green;
    logic side_red;
    logic side_yellow;
    logic side_green;
  } lamps_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // One lamp per road in every state; FLASH blinks main yellow with side red.
  function automatic lamps_t decode_lamps(state_t s, logic flash_on);
    lamps_t l;
    l = '0;
    case (s)
      ST_MAIN_GREEN:  begin l.main_green  = 1'b1; l.side_red    = 1'b1; end
      ST_MAIN_YELLOW: begin l.main_yellow = 1'b1; l.side_red    = 1'b1; end
      ST_SIDE_GREEN:  begin l.main_red    = 1'b1; l.side_green  = 1'b1; end
      ST_SIDE_YELLOW: begin l.main_red    = 1'b1; l.side_yellow = 1'b1; end
      ST_FLASH:       begin l.main_yellow = flash_on; l.side_red = flash_on; end
      default:        begin l.main_red    = 1'b1; l.side_red    = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Sensor inputs and lamp outputs of the intersection controller.
// Build option: INTERSECTION_NIGHT_FLASH_EN adds the night input.
interface intersection_controller_if;
  logic side_car;
  logic ped_btn;
`ifdef INTERSECTION_NIGHT_FLASH_EN
  logic night;
`endif
  logic main_red;
  logic main_yellow;
  logic main_green;
  logic side_red;
  logic side_yellow;
  logic side_green;
  logic walk;
  logic ped_wait;

  modport master (
`ifdef INTERSECTION_NIGHT_FLASH_EN
    input  night,
`endif
    input  side_car, ped_btn,
    output main_red, main_yellow, main_green,
    output side_red, side_yellow, side_green,
    output walk, ped_wait
  );

  modport slave (
`ifdef INTERSECTION_NIGHT_FLASH_EN
    output night,
`endif
    output side_car, ped_btn,
    input  main_red, main_yellow, main_green,
    input  side_red, side_yellow, side_green,
    input  walk, ped_wait
  );
endinterface

// File: rtl/intersection_controller_phase_timer.sv
// Loadable down-counter that times each phase; parks at zero.
module phase_timer #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer with pedestrian crossing over the main road.
// Build option: INTERSECTION_NIGHT_FLASH_EN adds the night-flash mode.
module intersection_controller
  import intersection_controller_pkg::*;
#(
  parameter int MIN_GREEN   = 8,
  parameter int SIDE_GREEN  = 6,
  parameter int YELLOW_TIME = 3,
  parameter int CLEAR_TIME  = 2
`ifdef INTERSECTION_NIGHT_FLASH_EN
  , parameter int FLASH_HALF = 4
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  intersection_controller_if.master  bus
);

`ifdef INTERSECTION_NIGHT_FLASH_EN
  localparam int MAX_DUR = max_int(max_int(max_int(MIN_GREEN, SIDE_GREEN),
                                           max_int(YELLOW_TIME, CLEAR_TIME)), FLASH_HALF);
`else
  localparam int MAX_DUR = max_int(max_int(MIN_GREEN, SIDE_GREEN),
                                   max_int(YELLOW_TIME, CLEAR_TIME));
`endif
  localparam int TW = $clog2(MAX_DUR) + 1;

  state_t          r_state;
  state_t          w_next;
  lamps_t          r_lamps;
  logic            r_ped_pending;
  logic            r_walk_active;
  logic            r_walk;
  logic            w_pend_next;
  logic            w_walk_act_next;
  logic            w_flash_next;
  logic            w_night;
  logic            w_done;
  logic            w_load;
  logic [TW-1:0]   w_load_val;

  function automatic logic [TW-1:0] dur(state_t s);
    case (s)
      ST_MAIN_GREEN:  return TW'(MIN_GREEN - 1);
      ST_MAIN_YELLOW: return TW'(YELLOW_TIME - 1);
      ST_SIDE_GREEN:  return TW'(SIDE_GREEN - 1);
      ST_SIDE_YELLOW: return TW'(YELLOW_TIME - 1);
`ifdef INTERSECTION_NIGHT_FLASH_EN
      ST_FLASH:       return TW'(FLASH_HALF - 1);
`endif
      default:        return TW'(CLEAR_TIME - 1);
    endcase
  endfunction

`ifdef INTERSECTION_NIGHT_FLASH_EN
  logic r_night_seq;
  logic r_flash_on;
  assign w_night      = bus.night;
  assign w_flash_next = (r_state != ST_FLASH) ? 1'b1 : (w_done ? ~r_flash_on : r_flash_on);
`else
  assign w_night      = 1'b0;
  assign w_flash_next = 1'b0;
`endif

  // Main green parks once its minimum expires and waits for demand.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_MAIN_GREEN:  if (w_done && (w_night || bus.side_car || r_ped_pending)) w_next = ST_MAIN_YELLOW;
      ST_MAIN_YELLOW: if (w_done) w_next = ST_ALL_RED_1;
`ifdef INTERSECTION_NIGHT_FLASH_EN
      ST_ALL_RED_1:   if (w_done) w_next = r_night_seq ? ST_FLASH : ST_SIDE_GREEN;
      ST_FLASH:       if (!w_night) w_next = ST_ALL_RED_2;
`else
      ST_ALL_RED_1:   if (w_done) w_next = ST_SIDE_GREEN;
`endif
      ST_SIDE_GREEN:  if (w_done) w_next = ST_SIDE_YELLOW;
      ST_SIDE_YELLOW: if (w_done) w_next = ST_ALL_RED_2;
      ST_ALL_RED_2:   if (w_done) w_next = ST_MAIN_GREEN;
      default:        w_next = ST_ALL_RED_2;
    endcase
  end

  // A press in the last clearance cycle is served by the side phase now starting.
  always_comb begin
    w_pend_next     = r_ped_pending | bus.ped_btn;
    w_walk_act_next = r_walk_active & (w_next == ST_SIDE_GREEN);
    if ((r_state == ST_ALL_RED_1) && (w_next == ST_SIDE_GREEN)) begin
      w_pend_next     = 1'b0;
      w_walk_act_next = r_ped_pending | bus.ped_btn;
    end
  end

  assign w_load     = (w_next != r_state) || ((r_state == ST_FLASH) && w_done);
  assign w_load_val = dur(w_next);

  phase_timer #(
    .WIDTH     (TW),
    .RESET_VAL (TW'(CLEAR_TIME - 1))
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_ALL_RED_2;
      r_lamps       <= decode_lamps(ST_ALL_RED_2, 1'b0);
      r_ped_pending <= 1'b0;
      r_walk_active <= 1'b0;
      r_walk        <= 1'b0;
`ifdef INTERSECTION_NIGHT_FLASH_EN
      r_night_seq   <= 1'b0;
      r_flash_on    <= 1'b0;
`endif
    end else begin
      r_state       <= w_next;
      r_lamps       <= decode_lamps(w_next, w_flash_next);
      r_ped_pending <= w_pend_next;
      r_walk_active <= w_walk_act_next;
      r_walk        <= w_walk_act_next & (w_next == ST_SIDE_GREEN);
`ifdef INTERSECTION_NIGHT_FLASH_EN
      r_flash_on    <= w_flash_next;
      if ((r_state == ST_MAIN_GREEN) && (w_next != ST_MAIN_GREEN)) r_night_seq <= w_night;
`endif
    end
  end

  assign bus.main_red    = r_lamps.main_red;
  assign bus.main_yellow = r_lamps.main_yellow;
  assign bus.main_green  = r_lamps.main_green;
  assign bus.side_red    = r_lamps.side_red;
  assign bus.side_yellow = r_lamps.side_yellow;
  assign bus.side_green  = r_lamps.side_green;
  assign bus.walk        = r_walk;
  assign bus.ped_wait    = r_ped_pending;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: directed phases plus random traffic against a phase-level model.
// Build option: INTERSECTION_NIGHT_FLASH_EN adds the night-flash section.
module tb_intersection_controller;

  localparam int MIN_GREEN   = 8;
  localparam int SIDE_GREEN  = 6;
  localparam int YELLOW_TIME = 3;
  localparam int CLEAR_TIME  = 2;
  localparam int FLASH_HALF  = 4;

  typedef enum int {PH_MG, PH_MY, PH_AR1, PH_SG, PH_SY, PH_AR2, PH_FL} phase_e;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  intersection_controller_if bus();

  int tests  = 0;
  int failed = 0;
  int cycle  = 0;

  phase_e mPhase;
  int     mElapsed;
  bit     mPend;
  bit     mWalkAct;
  bit     mNightSeq;
  logic   curCar, curBtn, curNight;

  intersection_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int durOf(phase_e p);
    case (p)
      PH_MY, PH_SY:   return YELLOW_TIME;
      PH_AR1, PH_AR2: return CLEAR_TIME;
      PH_SG:          return SIDE_GREEN;
      PH_FL:          return FLASH_HALF;
      default:        return MIN_GREEN;
    endcase
  endfunction

  task automatic modelReset();
    mPhase = PH_AR2; mElapsed = 0; mPend = 0; mWalkAct = 0; mNightSeq = 0;
  endtask

  // Each phase counts elapsed cycles; a phase ends after its duration (main green needs demand too).
  task automatic modelStep(input logic car, input logic btn, input logic nt);
    bit     adv;
    phase_e nxt;
    case (mPhase)
      PH_MG:   adv = (mElapsed >= MIN_GREEN - 1) && (car || mPend || nt);
      PH_FL:   adv = !nt;
      default: adv = (mElapsed == durOf(mPhase) - 1);
    endcase
    case (mPhase)
      PH_MG:   nxt = PH_MY;
      PH_MY:   nxt = PH_AR1;
      PH_AR1:  nxt = mNightSeq ? PH_FL : PH_SG;
      PH_SG:   nxt = PH_SY;
      PH_SY:   nxt = PH_AR2;
      PH_FL:   nxt = PH_AR2;
      default: nxt = PH_MG;
    endcase
    if (adv && mPhase == PH_AR1 && nxt == PH_SG) begin
      mWalkAct = mPend || btn;
      mPend    = 0;
    end else if (btn) begin
      mPend = 1;
    end
    if (adv) begin
      if (mPhase == PH_MG) mNightSeq = nt;
      if (mPhase == PH_SG) mWalkAct = 0;
      mPhase   = nxt;
      mElapsed = 0;
    end else begin
      mElapsed++;
    end
  endtask

  function automatic logic [6:0] expectedLamps();
    logic [2:0] m, s;
    bit         fl;
    fl = ((mElapsed / FLASH_HALF) % 2) == 0;
    m  = 3'b100;
    s  = 3'b100;
    case (mPhase)
      PH_MG: m = 3'b001;
      PH_MY: m = 3'b010;
      PH_SG: s = 3'b001;
      PH_SY: s = 3'b010;
      PH_FL: begin m = fl ? 3'b010 : 3'b000; s = fl ? 3'b100 : 3'b000; end
      default: ;
    endcase
    return {m, s, (mWalkAct && mPhase == PH_SG) ? 1'b1 : 1'b0};
  endfunction

  function automatic logic [6:0] observedLamps();
    return {bus.main_red, bus.main_yellow, bus.main_green,
            bus.side_red, bus.side_yellow, bus.side_green, bus.walk};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s cycle=%0d phase=%0d observed=%b expected=%b", tag, cycle, mPhase, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("lamps", observedLamps(), expectedLamps());
    check("ped_wait", {6'b0, bus.ped_wait}, {6'b0, mPend});
  endtask

  task automatic applyStimulus(input logic car, input logic btn, input logic nt);
    curCar = car; curBtn = btn; curNight = nt;
    bus.side_car = car;
    bus.ped_btn  = btn;
`ifdef INTERSECTION_NIGHT_FLASH_EN
    bus.night    = nt;
`endif
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep(curCar, curBtn, curNight);
    cycle++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic waitFor(input phase_e p, input int el, input int budget);
    int n;
    n = 0;
    while (!(mPhase == p && mElapsed == el) && n < budget) begin
      stepCycle();
      n++;
    end
    if (!(mPhase == p && mElapsed == el)) begin
      tests++;
      failed++;
      $display("[TB] FAIL waitFor observed=timeout expected=phase %0d elapsed %0d", p, el);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    modelReset();
    reset = 1'b0;

    // Reset held for two cycles, then idle: all-red for two cycles, main green rests.
    @(negedge clk); checkOutput();
    @(negedge clk); checkOutput();
    reset = 1'b1;
    repeat (54) stepCycle();

    // Continuous side demand cycles through every phase.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (80) stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitFor(PH_MG, MIN_GREEN + 2, 100);

    // Single pedestrian pulse while main rests.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (30) stepCycle();

    // Press in the last clearance cycle, then a second press during side green.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFor(PH_AR1, CLEAR_TIME - 1, 60);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (30) stepCycle();

    // Random traffic and pedestrian presses.
    for (int i = 0; i < 600; i++) begin
      logic car;
      car = ($urandom_range(0, 7) == 0) ? ~curCar : curCar;
      applyStimulus(car, ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0, 1'b0);
      stepCycle();
    end

    // Asynchronous reset mid side green with a pending request.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFor(PH_SG, 1, 80);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_lamps", observedLamps(), 7'b1001000);
    check("async_reset_ped_wait", {6'b0, bus.ped_wait}, 7'b0);
    modelReset();
    @(negedge clk); checkOutput();
    reset = 1'b1;
    repeat (40) stepCycle();

`ifdef INTERSECTION_NIGHT_FLASH_EN
    // Night flash entered from resting main green, then released.
    waitFor(PH_MG, MIN_GREEN, 100);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (40) stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (20) stepCycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
